keypad_decoder: RTL and testbench

- Consumer side of the keypad interface: takes the 4-bit note keycode plus the mode and sound edge pulses and turns them into a square-wave tone.
- Per-note half-period counts come from a table; a down-counter toggles the wave.
- mode_edge cycles a 4-step octave shift; sound_edge toggles mute.
- Sits between the keypad encoder and the audio output / PWM stage; single 10 MHz clock domain.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/tone_counter.sv | 57 +++++
 rtl/keypad_decoder.sv | 144 ++++++++++++++
 tb/tb_keypad_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the note table for the keypad tone decoder.
// Half-period table entries are 10 MHz clock counts for octave 0 (C4..C5).
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        SUSTAIN = 2'd2
    } state_t;

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_MAX  = 4'd12;
    localparam int         TABLE_W  = 16;

    localparam logic [TABLE_W-1:0] NOTE_HALF [0:12] = '{
        16'd19111, 16'd18039, 16'd17026, 16'd16071, 16'd15169,
        16'd14317, 16'd13514, 16'd12755, 16'd12039, 16'd11364,
        16'd10726, 16'd10124, 16'd9556
    };

    // Half-period for a keycode; codes past the table give 0 (silence).
    function automatic logic [TABLE_W-1:0] note_half(input logic [3:0] key);
        logic [TABLE_W-1:0] h;
        h = '0;
        if (key <= KEY_MAX) begin
            h = NOTE_HALF[key];
        end
        return h;
    endfunction

endpackage

// File: rtl/tone_counter.sv
// Loadable half-period down-counter that reloads at zero and toggles the wave.
// The wave output flop is gated by the mute value that takes effect on the
// same edge, so muting never disturbs the running phase.
import keypad_pkg::*;

module tone_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             run,
    input  logic             mute,
    input  logic [CNT_W-1:0] reload,
    output logic             wave
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             phase;
    logic             phase_next;

    // Next count and phase: clear wins over load, load wins over the countdown
    always_comb begin
        count_next = count;
        phase_next = phase;
        if (clear) begin
            count_next = '0;
            phase_next = 1'b0;
        end else if (load) begin
            count_next = reload;
            phase_next = 1'b0;
        end else if (run) begin
            if (count == '0) begin
                count_next = reload;
                phase_next = ~phase;
            end else begin
                count_next = count - CNT_W'(1);
            end
        end
    end

    // Counter, phase and the mute-gated wave output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            phase <= 1'b0;
            wave  <= 1'b0;
        end else begin
            count <= count_next;
            phase <= phase_next;
            wave  <= phase_next & ~mute;
        end
    end

endmodule

// File: rtl/keypad_decoder.sv
// Keypad tone decoder: turns a note keycode plus mode/sound pulses into a
// square-wave tone with a 4-step octave shift and a mute toggle.
// Optional release sustain is enabled with the KEYPAD_DECODER_SUSTAIN_EN macro.
import keypad_pkg::*;

module keypad_decoder #(
    parameter int          CNT_W          = 16,
    parameter logic [1:0]  OCT_RESET      = 2'd0,
    parameter int unsigned SUSTAIN_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keycode,
    input  logic       mode_edge,
    input  logic       sound_edge,
    output logic       wave,
    output logic       note_active,
    output logic [1:0] octave,
    output logic       muted
);

    state_t           state;
    state_t           state_next;
    logic             key_valid;
    logic [3:0]       key_eff;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] reload;
    logic [1:0]       octave_next;
    logic             muted_next;
    logic             load;
    logic             clear;
    logic             run;

    assign key_valid   = (keycode <= KEY_MAX);
    assign key_eff     = key_valid ? keycode : KEY_NONE;
    assign half        = CNT_W'(note_half(key_eff)) >> octave;
    assign octave_next = octave + 2'(mode_edge);
    assign muted_next  = muted ^ sound_edge;

`ifdef KEYPAD_DECODER_SUSTAIN_EN
    logic [31:0]      sus_cnt;
    logic [31:0]      sus_cnt_next;
    logic [CNT_W-1:0] held_half;

    // While no key is down the reload keeps using the last played pitch
    assign reload = (key_valid ? half : held_half) - CNT_W'(1);

    // Remember the latest valid half-period and the sustain count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_half <= '0;
            sus_cnt   <= '0;
        end else begin
            if (key_valid) begin
                held_half <= half;
            end
            sus_cnt <= sus_cnt_next;
        end
    end
`else
    assign reload = half - CNT_W'(1);
`endif

    // Next-state decode and counter control for the note FSM
    always_comb begin
        state_next = state;
        load       = 1'b0;
        clear      = 1'b0;
        run        = 1'b0;
`ifdef KEYPAD_DECODER_SUSTAIN_EN
        sus_cnt_next = '0;
`endif
        case (state)
            IDLE: begin
                if (key_valid) begin
                    state_next = PLAY;
                    load       = 1'b1;
                end else begin
                    clear = 1'b1;
                end
            end
            PLAY: begin
                if (key_valid) begin
                    run = 1'b1;
                end else begin
`ifdef KEYPAD_DECODER_SUSTAIN_EN
                    state_next = SUSTAIN;
                    run        = 1'b1;
`else
                    state_next = IDLE;
                    clear      = 1'b1;
`endif
                end
            end
`ifdef KEYPAD_DECODER_SUSTAIN_EN
            SUSTAIN: begin
                if (key_valid) begin
                    state_next = PLAY;
                    run        = 1'b1;
                end else if (sus_cnt == 32'(SUSTAIN_CYCLES - 1)) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end else begin
                    run          = 1'b1;
                    sus_cnt_next = sus_cnt + 32'd1;
                end
            end
`endif
            default: begin
                state_next = IDLE;
                clear      = 1'b1;
            end
        endcase
    end

    // State, octave, mute and note_active registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            octave      <= OCT_RESET;
            muted       <= 1'b0;
            note_active <= 1'b0;
        end else begin
            state       <= state_next;
            octave      <= octave_next;
            muted       <= muted_next;
            note_active <= (state_next != IDLE);
        end
    end

    tone_counter #(
        .CNT_W (CNT_W)
    ) u_tone (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .clear  (clear),
        .run    (run),
        .mute   (muted_next),
        .reload (reload),
        .wave   (wave)
    );

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder: a time-based tone model is compared
// against the outputs every cycle, and directed steps pin timing by hand.
module tb_keypad_decoder;

    localparam int SUS = 100;
`ifdef KEYPAD_DECODER_SUSTAIN_EN
    localparam bit SUS_EN = 1'b1;
`else
    localparam bit SUS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keycode;
    logic       mode_edge;
    logic       sound_edge;
    logic       wave;
    logic       note_active;
    logic [1:0] octave;
    logic       muted;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    int note_table [0:12] = '{19111, 18039, 17026, 16071, 15169, 14317,
                              13514, 12755, 12039, 11364, 10726, 10124, 9556};

    // Model: 0 silent, 1 key held, 2 sustaining
    int m_mode, m_level, m_left, m_oct, m_muted, m_last, m_sus;

    always #5 clk = ~clk;

    keypad_decoder #(
        .CNT_W          (16),
        .OCT_RESET      (2'd0),
        .SUSTAIN_CYCLES (SUS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .keycode     (keycode),
        .mode_edge   (mode_edge),
        .sound_edge  (sound_edge),
        .wave        (wave),
        .note_active (note_active),
        .octave      (octave),
        .muted       (muted)
    );

    function automatic int half_of(input int k, input int o);
        return note_table[k] / (1 << o);
    endfunction

    // One clock of the current half-period elapses; flip the level when it runs out
    task model_tick(input int h);
        m_left = m_left - 1;
        if (m_left == 0) begin
            m_level = 1 - m_level;
            m_left  = h;
        end
    endtask

    task check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task apply_stimulus(input logic [3:0] key, input logic mode_p, input logic sound_p);
        keycode    = key;
        mode_edge  = mode_p;
        sound_edge = sound_p;
    endtask

    task wait_level(input logic lvl, input int max_cycles, output int n);
        n = 0;
        while (wave !== lvl && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check_output("wave_wait", {31'd0, wave}, {31'd0, lvl});
    endtask

    // Behavioural tone model stepped on every clock edge
    always @(posedge clk or posedge rst) begin
        int  k;
        bit  kv;
        int  h;
        if (rst) begin
            m_mode = 0; m_level = 0; m_left = 0; m_oct = 0;
            m_muted = 0; m_last = 0; m_sus = 0;
        end else begin
            k  = int'(keycode);
            kv = (k <= 12);
            h  = kv ? half_of(k, m_oct) : 0;
            if (kv) m_last = h;
            case (m_mode)
                0: if (kv) begin m_mode = 1; m_level = 0; m_left = h; end
                1: begin
                    if (kv) model_tick(h);
                    else if (SUS_EN) begin m_mode = 2; m_sus = SUS; model_tick(m_last); end
                    else begin m_mode = 0; m_level = 0; end
                end
                default: begin
                    if (kv) begin m_mode = 1; model_tick(h); end
                    else begin
                        m_sus = m_sus - 1;
                        if (m_sus == 0) begin m_mode = 0; m_level = 0; end
                        else model_tick(m_last);
                    end
                end
            endcase
            m_oct   = (m_oct + int'(mode_edge)) % 4;
            m_muted = m_muted ^ int'(sound_edge);
        end
    end

    // Every-cycle comparison of {wave, note_active, octave, muted} against the model
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (checking && !rst) begin
            exp_v = 0;
            if (m_level == 1 && m_muted == 0) exp_v = exp_v | 32'd16;
            if (m_mode != 0) exp_v = exp_v | 32'd8;
            exp_v = exp_v | 32'(m_oct << 1) | 32'(m_muted);
            check_output("model", {27'd0, wave, note_active, octave, muted}, exp_v);
        end
    end

    initial begin
        int n;
        int n2;
        rst = 1'b0;
        apply_stimulus(4'hF, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_output("reset_wave", {31'd0, wave}, 0);
        check_output("reset_active", {31'd0, note_active}, 0);
        check_output("reset_octave", {30'd0, octave}, 0);
        check_output("reset_muted", {31'd0, muted}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);

        // A4 from idle: registered start, then 11364-clock half-periods
        apply_stimulus(4'd9, 1'b0, 1'b0);
        #1 check_output("active_before_edge", {31'd0, note_active}, 0);
        @(negedge clk);
        check_output("active_start", {31'd0, note_active}, 1);
        check_output("wave_start", {31'd0, wave}, 0);
        wait_level(1'b1, 30000, n);
        check_output("first_rise", n, 11364);
        wait_level(1'b0, 30000, n2);
        check_output("high_half", n2, 11364);
        check_output("period", n + n2, 22728);

        // Octave step mid half-period: current half completes, then 5682
        repeat (50) @(negedge clk);
        apply_stimulus(4'd9, 1'b1, 1'b0);
        @(negedge clk);
        apply_stimulus(4'd9, 1'b0, 1'b0);
        check_output("octave_after_mode", {30'd0, octave}, 1);
        wait_level(1'b1, 30000, n);
        check_output("half_unchanged", n + 51, 11364);
        wait_level(1'b0, 30000, n);
        check_output("half_oct1_high", n, 5682);
        wait_level(1'b1, 30000, n);
        check_output("half_oct1_low", n, 5682);

        // Asynchronous reset in the middle of a high half-period
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("midreset_wave", {31'd0, wave}, 0);
        check_output("midreset_active", {31'd0, note_active}, 0);
        check_output("midreset_octave", {30'd0, octave}, 0);
        check_output("midreset_muted", {31'd0, muted}, 0);
        apply_stimulus(4'hF, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_output("idle_after_reset", {30'd0, note_active, wave}, 0);

        // Four octave pulses wrap 1, 2, 3, 0
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(4'hF, 1'b1, 1'b0);
            @(negedge clk);
            apply_stimulus(4'hF, 1'b0, 1'b0);
            check_output("octave_step", {30'd0, octave}, 32'(i % 4));
        end

        // Both pulses together, then unmute and move to octave 3
        apply_stimulus(4'hF, 1'b1, 1'b1);
        @(negedge clk);
        apply_stimulus(4'hF, 1'b0, 1'b0);
        check_output("both_octave", {30'd0, octave}, 1);
        check_output("both_muted", {31'd0, muted}, 1);
        apply_stimulus(4'hF, 1'b0, 1'b1);
        @(negedge clk);
        apply_stimulus(4'hF, 1'b0, 1'b0);
        check_output("unmuted", {31'd0, muted}, 0);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(4'hF, 1'b1, 1'b0);
            @(negedge clk);
            apply_stimulus(4'hF, 1'b0, 1'b0);
        end
        check_output("octave_three", {30'd0, octave}, 3);

        // C4 at octave 3 (half 2388): mute while high, unmute keeps phase
        apply_stimulus(4'd0, 1'b0, 1'b0);
        repeat (3000) @(negedge clk);
        apply_stimulus(4'd0, 1'b0, 1'b1);
        @(negedge clk);
        apply_stimulus(4'd0, 1'b0, 1'b0);
        check_output("mute_on", {31'd0, muted}, 1);
        check_output("mute_wave", {31'd0, wave}, 0);
        repeat (3000) @(negedge clk);
        check_output("mute_still_low", {31'd0, wave}, 0);
        apply_stimulus(4'd0, 1'b0, 1'b1);
        @(negedge clk);
        apply_stimulus(4'd0, 1'b0, 1'b0);
        check_output("mute_off", {31'd0, muted}, 0);
        wait_level(1'b1, 6000, n);
        check_output("resume_phase", n, 1163);

`ifndef KEYPAD_DECODER_SUSTAIN_EN
        // Invalid codes release to idle on the next cycle
        apply_stimulus(4'd13, 1'b0, 1'b0);
        @(negedge clk);
        check_output("release13", {30'd0, note_active, wave}, 0);
        apply_stimulus(4'd0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check_output("replay", {31'd0, note_active}, 1);
        apply_stimulus(4'hF, 1'b0, 1'b0);
        @(negedge clk);
        check_output("release15", {30'd0, note_active, wave}, 0);
`else
        // Release sustains 100 clocks; a key mid-sustain keeps playing
        apply_stimulus(4'd9, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        apply_stimulus(4'hF, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check_output("sustain_hold", {31'd0, note_active}, 1);
        @(negedge clk);
        check_output("sustain_end", {30'd0, note_active, wave}, 0);
        apply_stimulus(4'd9, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        apply_stimulus(4'hF, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        apply_stimulus(4'd9, 1'b0, 1'b0);
        repeat (150) @(negedge clk);
        check_output("sustain_repress", {31'd0, note_active}, 1);
        apply_stimulus(4'hF, 1'b0, 1'b0);
        repeat (120) @(negedge clk);
        check_output("sustain_final", {31'd0, note_active}, 0);
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
